// File: rtl/dsp_core_pkg.sv
// Shared types and constants for the scalar DSP core.
// Sequencer states, branch condition codes and PC helpers.
package dsp_core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator for the fetch-stage sequencer.
// Purely combinational; codes 010/011 never take.
module branch_cmp
  import dsp_core_pkg::*;
(
  input  logic [2:0]      br_func,
  input  logic [XLEN-1:0] comp1,
  input  logic [XLEN-1:0] comp2,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (comp1 == comp2);
  assign lt_s = ($signed(comp1) < $signed(comp2));
  assign lt_u = (comp1 < comp2);

  always_comb begin
    taken = 1'b0;
    case (br_func)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = !lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: owns the PC, walks FETCH/EXEC/COMMIT
// and picks the next PC from jump, branch or pc4.
module pc_sequencer
  import dsp_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              SLOT_LEN = 4,
  parameter int              PC4_SLOT = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            execute,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  input  logic            br_valid,
  input  logic [2:0]      br_func,
  input  logic [XLEN-1:0] comp1,
  input  logic [XLEN-1:0] comp2,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [3:0]      slot,
  output logic            retire
);

  localparam logic [3:0] SLOT_LAST = 4'(SLOT_LEN - 1);
  localparam logic [3:0] SLOT_PC4  = 4'(PC4_SLOT);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [3:0]      slot_q, slot_d;
  logic            req_q, req_d;
  logic            retire_q, retire_d;

  logic            taken;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] nxt_pc;

  branch_cmp u_cmp (
    .br_func (br_func),
    .comp1   (comp1),
    .comp2   (comp2),
    .taken   (taken)
  );

  assign br_pc = pc_q + br_offset;

  always_comb begin
    nxt_pc = pc4_q;
    if (jmp_valid) begin
      nxt_pc = jmp_target;
    end else if (br_valid && taken) begin
      nxt_pc = br_pc;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
    slot_d   = slot_q;
    req_d    = 1'b0;
    retire_d = 1'b0;
    if (!execute) begin
      // A same-cycle ack is dropped along with the request
      state_d = ST_IDLE;
      pc4_d   = '0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          slot_d  = '0;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            slot_d  = '0;
            state_d = ST_EXEC;
          end else begin
            req_d = 1'b1;
          end
        end
        ST_EXEC: begin
          if (slot_q == SLOT_PC4) begin
            pc4_d = pc_q + XLEN'(4);
          end
          if (slot_q == SLOT_LAST) begin
            if (!stall) begin
              state_d = ST_COMMIT;
              slot_d  = '0;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        ST_COMMIT: begin
          pc_d     = align4(nxt_pc);
          retire_d = 1'b1;
          req_d    = 1'b1;
          state_d  = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      pc4_q    <= '0;
      instr_q  <= '0;
      slot_q   <= '0;
      req_q    <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      instr_q  <= instr_d;
      slot_q   <= slot_d;
      req_q    <= req_d;
      retire_q <= retire_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc4       = pc4_q;
  assign slot      = slot_q;
  assign retire    = retire_q;

endmodule
